// File: rtl/cpu_defs_pkg.sv
// Shared CPU-side definitions: CLINT register offsets and a small offset decoder.
package cpu_defs_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  typedef enum logic [2:0] {
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_NONE
  } clint_reg_e;

  function automatic clint_reg_e clint_decode(input logic [15:0] off);
    case (off)
      MSIP_OFF:        return REG_MSIP;
      MTIMECMP_LO_OFF: return REG_CMP_LO;
      MTIMECMP_HI_OFF: return REG_CMP_HI;
      MTIME_LO_OFF:    return REG_MTIME_LO;
      MTIME_HI_OFF:    return REG_MTIME_HI;
      default:         return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clint_mtime_cnt.sv
// 64-bit mtime counter with a TICK_DIV prescaler; bus writes to either half override a tick.
module clint_mtime_cnt #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] mtime
);

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic        tick;

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    // A written half takes wdata verbatim; the other half keeps its value, no carry.
    if (wr_lo) mtime_d = {mtime_q[63:32], wdata};
    if (wr_hi) mtime_d = {wdata, mtime_q[31:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= 16'd0;
      mtime_q <= 64'd0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime = mtime_q;

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: msip, mtimecmp and mtime behind a single-outstanding request/response bus.
// Handshake: a request moves on req_valid & req_ready, a response on rsp_valid & rsp_ready;
// the response is held unchanged until taken, and a new request is accepted only as it drains.
module clint_timer
  import cpu_defs_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        bus_req_valid,
  output logic        bus_req_ready,
  input  logic        bus_req_we,
  input  logic [31:0] bus_req_addr,
  input  logic [31:0] bus_req_wdata,
  output logic        bus_rsp_valid,
  input  logic        bus_rsp_ready,
  output logic [31:0] bus_rsp_rdata,
  output logic        bus_rsp_err,
  output logic        mip_msip,
  output logic        mip_mtip
);

  logic        msip_q, msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic        mtip_q, mtip_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        accept;
  logic        addr_err;
  logic [15:0] off;
  clint_reg_e  sel;
  logic        mt_wr_lo, mt_wr_hi;
  logic [63:0] mtime;
  logic        unused_addr_hi;

  // Only the low half of the address is decoded; the window repeats across the upper bits.
  assign unused_addr_hi = ^bus_req_addr[31:16];

  assign bus_req_ready = !rsp_valid_q | bus_rsp_ready;
  assign accept        = bus_req_valid & bus_req_ready;
  assign off           = bus_req_addr[15:0] - BASE_ADDR[15:0];

  clint_mtime_cnt #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime_cnt (
    .clk   (clk),
    .rst   (cpurst),
    .wr_lo (mt_wr_lo),
    .wr_hi (mt_wr_hi),
    .wdata (bus_req_wdata),
    .mtime (mtime)
  );

  always_comb begin
    sel         = clint_decode(off);
    addr_err    = (bus_req_addr[1:0] != 2'b00) || (sel == REG_NONE);
    msip_d      = msip_q;
    mtimecmp_d  = mtimecmp_q;
    shadow_d    = shadow_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mt_wr_lo    = 1'b0;
    mt_wr_hi    = 1'b0;
    mtip_d      = (mtime >= mtimecmp_q);

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = addr_err;
      rsp_rdata_d = 32'd0;
      if (!addr_err) begin
        if (bus_req_we) begin
          case (sel)
            REG_MSIP:     msip_d = bus_req_wdata[0];
            REG_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], bus_req_wdata};
            REG_CMP_HI:   mtimecmp_d = {bus_req_wdata, mtimecmp_q[31:0]};
            REG_MTIME_LO: mt_wr_lo = 1'b1;
            REG_MTIME_HI: mt_wr_hi = 1'b1;
            default: ;
          endcase
        end else begin
          case (sel)
            REG_MSIP:     rsp_rdata_d = {31'd0, msip_q};
            REG_CMP_LO:   rsp_rdata_d = mtimecmp_q[31:0];
            REG_CMP_HI:   rsp_rdata_d = mtimecmp_q[63:32];
            // Low read snapshots the high half so a lo/hi read pair is coherent.
            REG_MTIME_LO: begin
              rsp_rdata_d = mtime[31:0];
              shadow_d    = mtime[63:32];
            end
            REG_MTIME_HI: rsp_rdata_d = shadow_q;
            default: ;
          endcase
        end
      end
    end else if (bus_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cpurst) begin
      msip_q      <= 1'b0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_q    <= 32'd0;
      mtip_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      msip_q      <= msip_d;
      mtimecmp_q  <= mtimecmp_d;
      shadow_q    <= shadow_d;
      mtip_q      <= mtip_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus_rsp_valid = rsp_valid_q;
  assign bus_rsp_err   = rsp_err_q;
  assign bus_rsp_rdata = rsp_rdata_q;
  assign mip_msip      = msip_q;
  assign mip_mtip      = mtip_q;

endmodule
